// File: rtl/keyflow_port_divider.sv
// KeyFlow port selector: route ID (VLAN) mod switch key by restoring division,
// remainder mapped to a one-hot output port, with a one-entry request slot.
//
// state | meaning
// IDLE  | waiting; loads from the pending slot first, else a direct div_req
// DIV   | one restoring-division step per cycle, DIVIDER_WIDTH steps
// DONE  | result held on port_* until port_valid && port_ready
module keyflow_port_divider #(
    parameter int DIVIDER_WIDTH = 16,
    parameter int NUM_PORTS     = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     asclk,
    input  logic                     aresetn,
    input  logic                     div_req,
    input  logic [DIVIDER_WIDTH-1:0] dv_vlan,
    input  logic [DIVIDER_WIDTH-1:0] switch_key,
    output logic                     port_valid,
    input  logic                     port_ready,
    output logic [DIVIDER_WIDTH-1:0] port_remainder,
    output logic [NUM_PORTS-1:0]     port_onehot,
    output logic                     port_drop,
    output logic                     busy,
    output logic [DATA_WIDTH-1:0]    div_cnt,
    output logic [DATA_WIDTH-1:0]    err_cnt,
    output logic [DATA_WIDTH-1:0]    ovf_cnt
);

    localparam int CNT_W = $clog2(DIVIDER_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   r_state,    w_state_nxt;
    logic [DIVIDER_WIDTH-1:0] r_dvd,      w_dvd_nxt;
    logic [DIVIDER_WIDTH-1:0] r_dvs,      w_dvs_nxt;
    logic [DIVIDER_WIDTH-1:0] r_rem,      w_rem_nxt;
    logic [CNT_W-1:0]         r_iter,     w_iter_nxt;
    logic [NUM_PORTS-1:0]     r_onehot,   w_onehot_nxt;
    logic                     r_drop,     w_drop_nxt;
    logic                     r_slot_vld, w_slot_vld_nxt;
    logic [DIVIDER_WIDTH-1:0] r_slot_dvd, w_slot_dvd_nxt;
    logic [DIVIDER_WIDTH-1:0] r_slot_dvs, w_slot_dvs_nxt;
    logic [DATA_WIDTH-1:0]    r_div_cnt,  w_div_cnt_nxt;
    logic [DATA_WIDTH-1:0]    r_err_cnt,  w_err_cnt_nxt;
    logic [DATA_WIDTH-1:0]    r_ovf_cnt,  w_ovf_cnt_nxt;

    logic [DIVIDER_WIDTH:0]   w_trial;
    logic                     w_fits;
    logic [DIVIDER_WIDTH-1:0] w_rem_step;
    logic [NUM_PORTS-1:0]     w_map_onehot;
    logic                     w_map_drop;
    logic                     w_take;
    logic                     w_direct;
    logic                     w_store;
    logic                     w_ovf;
    logic [DIVIDER_WIDTH-1:0] w_ld_dvd;
    logic [DIVIDER_WIDTH-1:0] w_ld_dvs;

    // Partial remainder needs one extra bit before the trial subtraction.
    assign w_trial    = {r_rem, r_dvd[DIVIDER_WIDTH-1]};
    assign w_fits     = (w_trial >= {1'b0, r_dvs});
    assign w_rem_step = w_fits ? DIVIDER_WIDTH'(w_trial - {1'b0, r_dvs})
                               : w_trial[DIVIDER_WIDTH-1:0];

    always_comb begin
        w_map_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_map_onehot[i] = (w_rem_step == DIVIDER_WIDTH'(i));
        end
    end
    assign w_map_drop = ~|w_map_onehot;

    assign w_take   = (r_state == ST_IDLE) && r_slot_vld;
    assign w_direct = (r_state == ST_IDLE) && !r_slot_vld && div_req;
    assign w_store  = div_req && !w_direct && (!r_slot_vld || w_take);
    assign w_ovf    = div_req && r_slot_vld && !w_take;
    assign w_ld_dvd = w_take ? r_slot_dvd : dv_vlan;
    assign w_ld_dvs = w_take ? r_slot_dvs : switch_key;

    always_comb begin
        w_state_nxt    = r_state;
        w_dvd_nxt      = r_dvd;
        w_dvs_nxt      = r_dvs;
        w_rem_nxt      = r_rem;
        w_iter_nxt     = r_iter;
        w_onehot_nxt   = r_onehot;
        w_drop_nxt     = r_drop;
        w_slot_vld_nxt = r_slot_vld;
        w_slot_dvd_nxt = r_slot_dvd;
        w_slot_dvs_nxt = r_slot_dvs;
        w_div_cnt_nxt  = r_div_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        w_ovf_cnt_nxt  = r_ovf_cnt;

        if (w_store) begin
            w_slot_vld_nxt = 1'b1;
            w_slot_dvd_nxt = dv_vlan;
            w_slot_dvs_nxt = switch_key;
        end else if (w_take) begin
            w_slot_vld_nxt = 1'b0;
        end
        if (w_ovf) begin
            w_ovf_cnt_nxt = r_ovf_cnt + DATA_WIDTH'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_take || w_direct) begin
                    w_dvd_nxt = w_ld_dvd;
                    w_dvs_nxt = w_ld_dvs;
                    if (w_ld_dvs != '0) begin
                        w_state_nxt = ST_DIV;
                        w_rem_nxt   = '0;
                        w_iter_nxt  = CNT_W'(DIVIDER_WIDTH);
                    end else begin
                        w_state_nxt  = ST_DONE;
                        w_rem_nxt    = w_ld_dvd;
                        w_onehot_nxt = '0;
                        w_drop_nxt   = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                w_rem_nxt  = w_rem_step;
                w_dvd_nxt  = r_dvd << 1;
                w_iter_nxt = r_iter - CNT_W'(1);
                if (r_iter == CNT_W'(1)) begin
                    w_state_nxt  = ST_DONE;
                    w_onehot_nxt = w_map_onehot;
                    w_drop_nxt   = w_map_drop;
                end
            end
            ST_DONE: begin
                if (port_ready) begin
                    w_state_nxt   = ST_IDLE;
                    w_div_cnt_nxt = r_div_cnt + DATA_WIDTH'(1);
                    w_err_cnt_nxt = r_err_cnt + DATA_WIDTH'(r_drop);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            r_state    <= ST_IDLE;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_iter     <= '0;
            r_onehot   <= '0;
            r_drop     <= 1'b0;
            r_slot_vld <= 1'b0;
            r_slot_dvd <= '0;
            r_slot_dvs <= '0;
            r_div_cnt  <= '0;
            r_err_cnt  <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dvd      <= w_dvd_nxt;
            r_dvs      <= w_dvs_nxt;
            r_rem      <= w_rem_nxt;
            r_iter     <= w_iter_nxt;
            r_onehot   <= w_onehot_nxt;
            r_drop     <= w_drop_nxt;
            r_slot_vld <= w_slot_vld_nxt;
            r_slot_dvd <= w_slot_dvd_nxt;
            r_slot_dvs <= w_slot_dvs_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_ovf_cnt  <= w_ovf_cnt_nxt;
        end
    end

    assign port_valid     = (r_state == ST_DONE);
    assign busy           = (r_state != ST_IDLE);
    assign port_remainder = r_rem;
    assign port_onehot    = r_onehot;
    assign port_drop      = r_drop;
    assign div_cnt        = r_div_cnt;
    assign err_cnt        = r_err_cnt;
    assign ovf_cnt        = r_ovf_cnt;

endmodule
